// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline interlock logic.
package mips_pkg;

  localparam int unsigned REG_W   = 5;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned FWD_W   = 2;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [STATE_W-1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

  typedef enum logic [FWD_W-1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_EX   = 2'b10
  } fwd_sel_e;

  // In-flight producer as seen from decode: destination and write enable.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             reg_write;
  } producer_t;

  // Forward source for one operand: a non-load EX result beats a MEM result.
  function automatic fwd_sel_e fwd_sel(input logic ex_hit, input logic ex_load,
                                       input logic mem_hit);
    if (ex_hit && !ex_load) return FWD_EX;
    if (mem_hit)            return FWD_MEM;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side interlock bus between the pipeline datapath and hazard_ctrl.
// The fwd_a/fwd_b selects exist only when HAZ_FWD_EN is defined.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import mips_pkg::*;

  logic [REG_W-1:0]   id_rs;
  logic [REG_W-1:0]   id_rt;
  logic               id_uses_rs;
  logic               id_uses_rt;
  logic [REG_W-1:0]   ex_rd;
  logic               ex_reg_write;
  logic               ex_mem_read;
  logic [REG_W-1:0]   mem_rd;
  logic               mem_reg_write;
  logic               br_taken;
  logic               cnt_clr;
  logic               pc_we;
  logic               if_id_we;
  logic               id_ex_bubble;
  logic               if_id_flush;
  logic               ex_mem_flush;
  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;
`ifdef HAZ_FWD_EN
  logic [FWD_W-1:0]   fwd_a;
  logic [FWD_W-1:0]   fwd_b;
`endif

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_reg_write, ex_mem_read,
    output mem_rd, mem_reg_write, br_taken, cnt_clr,
`ifdef HAZ_FWD_EN
    input  fwd_a, fwd_b,
`endif
    input  pc_we, if_id_we, id_ex_bubble, if_id_flush, ex_mem_flush,
    input  state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rd, ex_reg_write, ex_mem_read,
    input  mem_rd, mem_reg_write, br_taken, cnt_clr,
`ifdef HAZ_FWD_EN
    output fwd_a, fwd_b,
`endif
    output pc_we, if_id_we, id_ex_bubble, if_id_flush, ex_mem_flush,
    output state, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_cmp.sv
// Matches one decode source operand against the EX and MEM producers.
module hazard_cmp
  import mips_pkg::*;
(
  input  logic             uses_i,
  input  logic [REG_W-1:0] src_i,
  input  producer_t        ex_i,
  input  producer_t        mem_i,
  output logic             ex_hit_c_o,
  output logic             mem_hit_c_o
);

  logic src_live;

  // r0 is hardwired, so reading it never depends on a producer.
  assign src_live    = uses_i & (src_i != REG_ZERO);
  assign ex_hit_c_o  = src_live & ex_i.reg_write  & (src_i == ex_i.rd);
  assign mem_hit_c_o = src_live & mem_i.reg_write & (src_i == mem_i.rd);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: RAW stall, branch flush, event counters.
// HAZ_FWD_EN: when defined, only load-use in EX stalls and fwd_a/fwd_b
// forward selects are driven; otherwise EX and MEM matches both interlock.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  hz_state_e        state_q, state_d;
  logic             id_valid_q, id_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  producer_t ex_prod, mem_prod;
  logic      rs_ex_hit, rs_mem_hit, rt_ex_hit, rt_mem_hit;
  logic      haz;
  logic      pc_we_c, if_id_we_c, bubble_c, if_id_flush_c, ex_mem_flush_c;

  assign ex_prod.rd         = hz.ex_rd;
  assign ex_prod.reg_write  = hz.ex_reg_write;
  assign mem_prod.rd        = hz.mem_rd;
  assign mem_prod.reg_write = hz.mem_reg_write;

  hazard_cmp u_cmp_rs (
    .uses_i      (hz.id_uses_rs),
    .src_i       (hz.id_rs),
    .ex_i        (ex_prod),
    .mem_i       (mem_prod),
    .ex_hit_c_o  (rs_ex_hit),
    .mem_hit_c_o (rs_mem_hit)
  );

  hazard_cmp u_cmp_rt (
    .uses_i      (hz.id_uses_rt),
    .src_i       (hz.id_rt),
    .ex_i        (ex_prod),
    .mem_i       (mem_prod),
    .ex_hit_c_o  (rt_ex_hit),
    .mem_hit_c_o (rt_mem_hit)
  );

`ifdef HAZ_FWD_EN
  // With bypassing, only a load still in EX cannot be satisfied in time.
  assign haz = id_valid_q & hz.ex_mem_read & (rs_ex_hit | rt_ex_hit);

  logic fwd_off;
  assign fwd_off  = rst | ~id_valid_q | hz.br_taken;
  assign hz.fwd_a = fwd_off ? FWD_NONE : fwd_sel(rs_ex_hit, hz.ex_mem_read, rs_mem_hit);
  assign hz.fwd_b = fwd_off ? FWD_NONE : fwd_sel(rt_ex_hit, hz.ex_mem_read, rt_mem_hit);
`else
  // Without bypassing, any EX or MEM producer of a source blocks decode.
  assign haz = id_valid_q & (rs_ex_hit | rs_mem_hit | rt_ex_hit | rt_mem_hit);

  logic unused_ex_mem_read;
  assign unused_ex_mem_read = hz.ex_mem_read;
`endif

  // Pipeline controls: reset holds everything flushed, flush beats stall.
  always_comb begin
    pc_we_c        = 1'b1;
    if_id_we_c     = 1'b1;
    bubble_c       = 1'b0;
    if_id_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;
    if (rst) begin
      pc_we_c        = 1'b0;
      if_id_we_c     = 1'b0;
      bubble_c       = 1'b1;
      if_id_flush_c  = 1'b1;
      ex_mem_flush_c = 1'b1;
    end else if (hz.br_taken) begin
      bubble_c       = 1'b1;
      if_id_flush_c  = 1'b1;
      ex_mem_flush_c = 1'b1;
    end else if (haz) begin
      pc_we_c    = 1'b0;
      if_id_we_c = 1'b0;
      bubble_c   = 1'b1;
    end
  end

  // Next-state: FSM, decode-valid tracking and saturating counters.
  always_comb begin
    state_d     = state_q;
    id_valid_d  = id_valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (hz.br_taken) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        RUN:     if (haz)  state_d = STALL;
        STALL:   if (!haz) state_d = RUN;
        FLUSH:   state_d = RUN;
        default: state_d = RUN;
      endcase
    end

    if (hz.br_taken)     id_valid_d = 1'b0;
    else if (if_id_we_c) id_valid_d = 1'b1;

    if (hz.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_we_c && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (hz.br_taken && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      id_valid_q  <= id_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.pc_we        = pc_we_c;
  assign hz.if_id_we     = if_id_we_c;
  assign hz.id_ex_bubble = bubble_c;
  assign hz.if_id_flush  = if_id_flush_c;
  assign hz.ex_mem_flush = ex_mem_flush_c;
  assign hz.state        = state_q;
  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;

endmodule
